// File: rtl/replica_run_ctrl.sv
// Annealing run sequencer: opt step on all replicas, wait for every completion,
// exchange step with alternating pairing, repeated run_times times.
// Optional build macro RUN_ABORT_EN: run_write with run_times==0 during a run
// requests a clean stop at the end of the current iteration.
module replica_run_ctrl #(
  parameter int NODE_NUM = 32,
  parameter int TIMES_W  = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_write,
  input  logic [TIMES_W-1:0]  run_times,
  output logic                opt_run,
  input  logic [NODE_NUM-1:0] opt_done,
  output logic                exchange_run,
  output logic                exchange_odd,
  input  logic                exchange_done,
  output logic                running,
  output logic [TIMES_W-1:0]  remaining
);

  typedef enum logic [2:0] {IDLE, OPT, OWAIT, EXCH, EWAIT} state_t;

  localparam logic [TIMES_W-1:0] ONE = TIMES_W'(1);

  state_t              state, state_nxt;
  logic [NODE_NUM-1:0] done_mask, done_mask_nxt;
  logic [NODE_NUM-1:0] done_seen;
  logic [TIMES_W-1:0]  remaining_nxt;
  logic                odd_nxt;
  logic                running_nxt;
  logic                abort_hit;

  assign done_seen = done_mask | opt_done;

`ifdef RUN_ABORT_EN
  logic abort_q;

  // Sticky stop request; the iteration in flight always finishes both steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      abort_q <= 1'b0;
    else if (state_nxt == IDLE)
      abort_q <= 1'b0;
    else if (running && run_write && (run_times == '0))
      abort_q <= 1'b1;
  end

  assign abort_hit = abort_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    done_mask_nxt = done_mask;
    remaining_nxt = remaining;
    odd_nxt       = exchange_odd;
    running_nxt   = running;
    case (state)
      IDLE: begin
        if (run_write && (run_times != '0)) begin
          state_nxt     = OPT;
          remaining_nxt = run_times;
          odd_nxt       = 1'b0;
          done_mask_nxt = '0;
          running_nxt   = 1'b1;
        end
      end
      OPT: begin
        done_mask_nxt = '0;
        state_nxt     = OWAIT;
      end
      OWAIT: begin
        // The final pulse is counted in the cycle it arrives.
        done_mask_nxt = done_seen;
        if (&done_seen)
          state_nxt = EXCH;
      end
      EXCH: state_nxt = EWAIT;
      EWAIT: begin
        if (exchange_done) begin
          if ((remaining == ONE) || abort_hit) begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
            running_nxt   = 1'b0;
          end else begin
            state_nxt     = OPT;
            remaining_nxt = remaining - ONE;
            odd_nxt       = ~exchange_odd;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Step pulses are registered from the next state so they coincide with OPT/EXCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      done_mask    <= '0;
      remaining    <= '0;
      exchange_odd <= 1'b0;
      running      <= 1'b0;
      opt_run      <= 1'b0;
      exchange_run <= 1'b0;
    end else begin
      state        <= state_nxt;
      done_mask    <= done_mask_nxt;
      remaining    <= remaining_nxt;
      exchange_odd <= odd_nxt;
      running      <= running_nxt;
      opt_run      <= (state_nxt == OPT);
      exchange_run <= (state_nxt == EXCH);
    end
  end

endmodule

// File: tb/tb_replica_run_ctrl.sv
// Scoreboard bench for replica_run_ctrl: directed runs push expected step events,
// a negedge monitor compares each observed pulse / run end against the queue.
module tb_replica_run_ctrl;

  localparam int NODE_NUM = 32;
  localparam int TIMES_W  = 24;

  localparam logic [1:0] K_OPT = 2'd0;
  localparam logic [1:0] K_EXC = 2'd1;
  localparam logic [1:0] K_END = 2'd2;

  typedef struct packed {
    logic [1:0]         kind;
    int                 cyc;
    logic               odd;
    logic [TIMES_W-1:0] rem;
    logic               run;
  } ev_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                run_write;
  logic [TIMES_W-1:0]  run_times;
  logic                opt_run;
  logic [NODE_NUM-1:0] opt_done;
  logic                exchange_run;
  logic                exchange_odd;
  logic                exchange_done;
  logic                running;
  logic [TIMES_W-1:0]  remaining;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_opt = 0;
  int   n_exc = 0;
  logic run_prev = 1'b0;
  ev_t  exp_q[$];

  replica_run_ctrl #(.NODE_NUM(NODE_NUM), .TIMES_W(TIMES_W)) dut (
    .clk(clk), .reset(reset), .run_write(run_write), .run_times(run_times),
    .opt_run(opt_run), .opt_done(opt_done), .exchange_run(exchange_run),
    .exchange_odd(exchange_odd), .exchange_done(exchange_done),
    .running(running), .remaining(remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_ev(input logic [1:0] k);
    ev_t act, e;
    act = '{kind: k, cyc: cyc, odd: exchange_odd, rem: remaining, run: running};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d odd=%0d rem=%0d run=%0d, expected none",
               act.kind, act.cyc, act.odd, act.rem, act.run);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d odd=%0d rem=%0d run=%0d, expected kind=%0d cyc=%0d odd=%0d rem=%0d run=%0d",
                 act.kind, act.cyc, act.odd, act.rem, act.run, e.kind, e.cyc, e.odd, e.rem, e.run);
      end
    end
  endtask

  // Monitor: every step pulse and every fall of running is an observable event.
  always @(negedge clk) begin
    if (opt_run) begin
      n_opt++;
      check_ev(K_OPT);
    end
    if (exchange_run) begin
      n_exc++;
      check_ev(K_EXC);
    end
    if (run_prev && !running) check_ev(K_END);
    run_prev = running;
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] k, input int c, input logic odd,
                      input int rem, input logic run);
    ev_t e;
    e = '{kind: k, cyc: c, odd: odd, rem: TIMES_W'(rem), run: run};
    exp_q.push_back(e);
  endtask

  // One iteration with every responder answering 5 cycles after its step pulse.
  task automatic drive_iter(input int base, input bit inj, input int inj_times);
    goto(base + 2);
    if (inj) begin
      run_write = 1'b1;
      run_times = TIMES_W'(inj_times);
    end
    goto(base + 3);
    run_write = 1'b0;
    goto(base + 5);
    opt_done = '1;
    goto(base + 6);
    opt_done = '0;
    goto(base + 11);
    exchange_done = 1'b1;
    goto(base + 12);
    exchange_done = 1'b0;
  endtask

  task automatic run_seq(input int n, input int inj_iter, input int inj_times);
    int t, a, niters;
    niters = n;
`ifdef RUN_ABORT_EN
    if (inj_iter >= 0 && inj_times == 0) niters = inj_iter + 1;
`endif
    t = cyc;
    a = t + 1;
    for (int k = 0; k < niters; k++) begin
      push(K_OPT, a + 12*k,     k[0], n - k, 1'b1);
      push(K_EXC, a + 12*k + 6, k[0], n - k, 1'b1);
    end
    push(K_END, a + 12*niters, (niters - 1) % 2 == 1, 0, 1'b0);
    run_write = 1'b1;
    run_times = TIMES_W'(n);
    goto(t + 1);
    run_write = 1'b0;
    for (int k = 0; k < niters; k++)
      drive_iter(a + 12*k, k == inj_iter, inj_times);
    goto(a + 12*niters + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, a, o0, e0;
    logic [NODE_NUM-1:0] v;
    reset = 1'b1; run_write = 1'b0; run_times = '0; opt_done = '0; exchange_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_running", running, 0);
    check("rst_opt_run", opt_run, 0);
    check("rst_exchange_run", exchange_run, 0);
    check("rst_exchange_odd", exchange_odd, 0);
    check("rst_remaining", remaining, 0);
    reset = 1'b0;
    goto(cyc + 2);

    // Three iterations, odd sequence 0,1,0, remaining 3,2,1 then 0.
    o0 = n_opt; e0 = n_exc;
    run_seq(3, -1, 0);
    check("t1_opt_count", n_opt - o0, 3);
    check("t1_exc_count", n_exc - e0, 3);
    check("t1_remaining_end", remaining, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Staggered completions; replica 31 last at +40, replica 7 twice.
    t = cyc; a = t + 1;
    push(K_OPT, a, 1'b0, 1, 1'b1);
    push(K_EXC, a + 41, 1'b0, 1, 1'b1);
    push(K_END, a + 46, 1'b0, 0, 1'b0);
    run_write = 1'b1; run_times = TIMES_W'(1);
    goto(a);
    run_write = 1'b0;
    for (int c = 2; c <= 40; c++) begin
      goto(a + c);
      v = '0;
      for (int i = 0; i < 31; i++) if (c == 2 + i) v[i] = 1'b1;
      if (c == 40) v[31] = 1'b1;
      if (c == 20) v[7] = 1'b1;
      opt_done = v;
    end
    goto(a + 41);
    opt_done = '0;
    goto(a + 45);
    exchange_done = 1'b1;
    goto(a + 46);
    exchange_done = 1'b0;
    goto(a + 49);
    check("t2_queue_empty", exp_q.size(), 0);

    // run_times == 0 from IDLE does nothing.
    run_write = 1'b1; run_times = '0;
    goto(cyc + 1);
    run_write = 1'b0;
    goto(cyc + 8);
    check("t3_running", running, 0);
    check("t3_remaining", remaining, 0);

    // Second request during a 2-iteration run is not accepted.
    run_seq(2, 0, 5);
    goto(cyc + 10);
    check("t4_running_after", running, 0);
    check("t4_remaining_after", remaining, 0);
    check("t4_queue_empty", exp_q.size(), 0);

    // Reset in EWAIT of iteration 2 of 4, then stray done pulses.
    t = cyc; a = t + 1;
    push(K_OPT, a,      1'b0, 4, 1'b1);
    push(K_EXC, a + 6,  1'b0, 4, 1'b1);
    push(K_OPT, a + 12, 1'b1, 3, 1'b1);
    push(K_EXC, a + 18, 1'b1, 3, 1'b1);
    push(K_END, a + 20, 1'b0, 0, 1'b0);
    run_write = 1'b1; run_times = TIMES_W'(4);
    goto(a);
    run_write = 1'b0;
    drive_iter(a, 1'b0, 0);
    goto(a + 17);
    opt_done = '1;
    goto(a + 18);
    opt_done = '0;
    goto(a + 20);
    #2;
    reset = 1'b1;
    #1;
    check("t5_running", running, 0);
    check("t5_opt_run", opt_run, 0);
    check("t5_exchange_run", exchange_run, 0);
    check("t5_exchange_odd", exchange_odd, 0);
    check("t5_remaining", remaining, 0);
    goto(a + 22);
    reset = 1'b0;
    goto(a + 23);
    exchange_done = 1'b1;
    goto(a + 24);
    exchange_done = 1'b0;
    opt_done = '1;
    goto(a + 25);
    opt_done = '0;
    goto(a + 34);
    check("t5_running_after", running, 0);
    check("t5_queue_empty", exp_q.size(), 0);

`ifdef RUN_ABORT_EN
    // Abort requested in iteration 2 OWAIT: two full iterations then stop.
    o0 = n_opt;
    run_seq(10, 1, 0);
    check("t6_opt_count", n_opt - o0, 2);
    check("t6_remaining", remaining, 0);
    check("t6_running", running, 0);
    check("t6_queue_empty", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
